j1_vectored: RTL and testbench

Parametrised next-generation 16-bit J1 stack CPU core for the iCE40 Forth system.
- Memory size, stack depth and interrupt line count are generics.
- Adds prioritised vectored interrupts with per-line acknowledge, IO wait-state stalling via io_ready, and sticky stack over/underflow flags.
- Sits between the unified code/data RAM (internal) and the SoC IO bus.

---
 rtl/j1_vectored.sv | 211 +++++++++++++++++++++
 tb/tb_j1_vectored.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/j1_vectored.sv
// rtl/j1_vectored.sv - 16-bit J1 stack CPU with vectored interrupts, IO wait states and sticky stack faults
module j1_vectored #(
    parameter int MEMWORDS = 8192,
    parameter int DEPTH    = 32,
    parameter int NIRQ     = 4,
    parameter     INITFILE = "build/iceimage.hex"
) (
    input  logic            clk,
    input  logic            resetq,
    output logic            io_rd,
    output logic            io_wr,
    output logic [15:0]     io_addr,
    output logic [15:0]     io_dout,
    input  logic [15:0]     io_din,
    input  logic            io_ready,
    input  logic [NIRQ-1:0] irq,
    output logic [NIRQ-1:0] irq_ack,
    output logic [1:0]      stack_fault
);
    localparam int AW = $clog2(MEMWORDS);
    localparam int SW = $clog2(DEPTH);

    logic [15:0]   mem_q  [MEMWORDS];
    logic [15:0]   dstk_q [DEPTH];
    logic [15:0]   rstk_q [DEPTH];

    logic [15:0]   insn_q;
    logic [15:0]   pc_q, pc_d;
    logic [15:0]   t_q, t_d;
    logic [SW-1:0] dsp_q, dsp_d, rsp_q, rsp_d;
    logic [1:0]    fault_q, fault_d;
    logic          reboot_q, fetch_q, fetch_d;

    logic [15:0]   n_top, r_top, alu, pc_plus2, r_wdata, target;
    logic [31:0]   prod;
    logic [1:0]    d_delta, r_delta;
    logic [4:0]    op;
    logic [2:0]    func;
    logic [2:0]    irq_idx;
    logic          is_alu, io_insn, active, take, stall, commit;
    logic          dwe, rwe, ram_we;

    function automatic logic [15:0] ret_addr(input logic [15:0] a);
        // bit15 marks an interrupt return: strip it and turn IE back on
        return a[15] ? {1'b0, a[14:1], 1'b1} : a;
    endfunction

    function automatic logic underflow(input logic [1:0] d, input logic [SW-1:0] p);
        return (d == 2'b11 && p == '0) || (d == 2'b10 && p < SW'(2));
    endfunction

    assign n_top    = dstk_q[dsp_q];
    assign r_top    = rstk_q[rsp_q];
    assign pc_plus2 = pc_q + 16'd2;
    assign target   = {2'b00, insn_q[12:0], pc_q[0]};
    assign op       = insn_q[12:8];
    assign func     = insn_q[6:4];
    assign prod     = 32'(t_q) * 32'(n_top);

    assign is_alu  = (insn_q[15:13] == 3'b011);
    assign io_insn = is_alu && (func == 3'd4 || func == 3'd5);
    assign active  = !reboot_q && !fetch_q;
    assign io_wr   = active && is_alu && (func == 3'd4);
    assign io_rd   = active && is_alu && (func == 3'd5);
    assign stall   = (io_wr || io_rd) && !io_ready;
    assign commit  = !reboot_q && !stall;

    // IO instructions are never preempted so each strobe runs its full wait sequence
    assign take    = active && pc_q[0] && (|irq) && !io_insn;

    assign io_addr     = t_q;
    assign io_dout     = n_top;
    assign stack_fault = fault_q;
    assign irq_ack     = take ? (NIRQ'(1) << irq_idx) : '0;

    always_comb begin
        irq_idx = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (irq[i]) irq_idx = 3'(i);
        end
    end

    always_comb begin
        alu = t_q;
        case (op)
            5'd0:    alu = t_q;
            5'd1:    alu = n_top;
            5'd2:    alu = t_q + n_top;
            5'd3:    alu = t_q & n_top;
            5'd4:    alu = t_q | n_top;
            5'd5:    alu = t_q ^ n_top;
            5'd6:    alu = ~t_q;
            5'd7:    alu = {16{n_top == t_q}};
            5'd8:    alu = {16{$signed(n_top) < $signed(t_q)}};
            5'd9:    alu = 16'($signed(t_q) >>> 1);
            5'd10:   alu = {t_q[14:0], 1'b0};
            5'd11:   alu = r_top;
            5'd12:   alu = n_top - t_q;
            5'd13:   alu = io_din;
            5'd14:   alu = 16'(dsp_q);
            5'd15:   alu = {16{n_top < t_q}};
            5'd16:   alu = n_top << t_q[3:0];
            5'd17:   alu = n_top >> t_q[3:0];
            5'd18:   alu = 16'($signed(n_top) >>> t_q[3:0]);
            5'd19:   alu = 16'(rsp_q);
            5'd20:   alu = prod[15:0];
            5'd21:   alu = prod[31:16];
            5'd22:   alu = t_q + 16'd1;
            5'd23:   alu = t_q - 16'd1;
            default: alu = t_q;
        endcase
    end

    always_comb begin
        t_d     = t_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        fetch_d = 1'b0;
        d_delta = 2'b00;
        r_delta = 2'b00;
        dwe     = 1'b0;
        rwe     = 1'b0;
        ram_we  = 1'b0;
        r_wdata = pc_plus2;
        if (reboot_q) begin
            pc_d = '0;
        end else if (fetch_q) begin
            // the word read from a bit14 address is data: push it and return
            t_d     = insn_q;
            d_delta = 2'b01;
            dwe     = 1'b1;
            r_delta = 2'b11;
            pc_d    = ret_addr(r_top);
            fetch_d = pc_d[14];
        end else if (take) begin
            r_delta = 2'b01;
            rwe     = 1'b1;
            r_wdata = {1'b1, pc_q[14:1], 1'b0};
            pc_d    = (16'(irq_idx) + 16'd1) << 1;
        end else if (insn_q[15]) begin
            t_d     = {1'b0, insn_q[14:0]};
            d_delta = 2'b01;
            dwe     = 1'b1;
            pc_d    = pc_plus2;
        end else begin
            case (insn_q[14:13])
                2'b00: pc_d = target;
                2'b01: begin
                    d_delta = 2'b11;
                    t_d     = n_top;
                    pc_d    = (t_q == 16'd0) ? target : pc_plus2;
                end
                2'b10: begin
                    r_delta = 2'b01;
                    rwe     = 1'b1;
                    pc_d    = target;
                end
                default: begin
                    t_d     = alu;
                    d_delta = insn_q[1:0];
                    r_delta = insn_q[3:2];
                    dwe     = (func == 3'd1);
                    rwe     = (func == 3'd2);
                    ram_we  = (func == 3'd3);
                    if (func == 3'd2) r_wdata = t_q;
                    pc_d    = insn_q[7] ? ret_addr(r_top) : pc_plus2;
                    fetch_d = insn_q[7] && pc_d[14];
                    if (func == 3'd6) pc_d[0] = 1'b0;
                    else if (func == 3'd7) pc_d[0] = 1'b1;
                end
            endcase
        end
        dsp_d = dsp_q + SW'($signed(d_delta));
        rsp_d = rsp_q + SW'($signed(r_delta));
        if ((d_delta == 2'b01 && dsp_q == SW'(DEPTH - 1)) || underflow(d_delta, dsp_q))
            fault_d[0] = 1'b1;
        if ((r_delta == 2'b01 && rsp_q == SW'(DEPTH - 1)) || underflow(r_delta, rsp_q))
            fault_d[1] = 1'b1;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            pc_q     <= '0;
            t_q      <= '0;
            dsp_q    <= '0;
            rsp_q    <= '0;
            fault_q  <= '0;
            reboot_q <= 1'b1;
            fetch_q  <= 1'b0;
        end else if (!stall) begin
            pc_q     <= pc_d;
            t_q      <= t_d;
            dsp_q    <= dsp_d;
            rsp_q    <= rsp_d;
            fault_q  <= fault_d;
            reboot_q <= 1'b0;
            fetch_q  <= fetch_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) insn_q <= mem_q[pc_d[AW:1]];
        if (commit && ram_we) mem_q[t_q[AW:1]] <= n_top;
    end

    always_ff @(posedge clk) begin
        if (commit && dwe) dstk_q[dsp_d] <= t_q;
        if (commit && rwe) rstk_q[rsp_d] <= r_wdata;
    end

endmodule

// File: tb/tb_j1_vectored.sv
// tb/tb_j1_vectored.sv - directed self-checking bench for j1_vectored
module tb_j1_vectored;
    logic        clk = 1'b0;
    logic        resetq = 1'b1;
    logic        io_rd, io_wr;
    logic [15:0] io_addr, io_dout;
    logic [15:0] io_din = 16'h0000;
    logic        io_ready = 1'b1;
    logic [3:0]  irq = 4'h0;
    logic [3:0]  irq_ack;
    logic [1:0]  stack_fault;

    int checks = 0;
    int failures = 0;

    j1_vectored #(.MEMWORDS(1024), .DEPTH(4), .NIRQ(4)) dut (
        .clk(clk), .resetq(resetq), .io_rd(io_rd), .io_wr(io_wr),
        .io_addr(io_addr), .io_dout(io_dout), .io_din(io_din), .io_ready(io_ready),
        .irq(irq), .irq_ack(irq_ack), .stack_fault(stack_fault)
    );

    always #5 clk = ~clk;

    logic [15:0] va  [11] = '{16'd5, 16'h1234, 16'h1234, 16'h1234, 16'd3, 16'h7000, 16'd5, 16'd3, 16'h0F0F, 16'h4000, 16'h1234};
    logic [15:0] vb  [11] = '{16'd3, 16'h0111, 16'h0010, 16'h0010, 16'd4, 16'd12, 16'd5, 16'd5, 16'h00FF, 16'h0001, 16'h5678};
    logic [4:0]  vop [11] = '{5'd12, 5'd2, 5'd20, 5'd21, 5'd16, 5'd17, 5'd7, 5'd8, 5'd3, 5'd22, 5'd5};
    logic [15:0] vex [11] = '{16'd2, 16'h1345, 16'h2340, 16'h0001, 16'h0030, 16'h0007, 16'hFFFF, 16'hFFFF, 16'h000F, 16'h0002, 16'h444C};

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic begin_load;
        @(negedge clk);
        resetq = 1'b0;
        for (int i = 0; i < 1024; i++) dut.mem_q[i] = 16'h0000;
    endtask

    task automatic put(input int a, input logic [15:0] w);
        dut.mem_q[a] = w;
    endtask

    task automatic go;
        tick(1);
        resetq = 1'b1;
    endtask

    task automatic test_reset;
        irq = 4'hF;
        #2 resetq = 1'b0;
        tick(2);
        checks++; if (io_rd !== 1'b0 || io_wr !== 1'b0) begin failures++; $display("FAIL reset_strobes: got rd=%b wr=%b want 0 0", io_rd, io_wr); end
        checks++; if (io_addr !== 16'h0000) begin failures++; $display("FAIL reset_io_addr: got %h want 0000", io_addr); end
        checks++; if (irq_ack !== 4'h0) begin failures++; $display("FAIL reset_irq_ack: got %b want 0000", irq_ack); end
        checks++; if (stack_fault !== 2'b00) begin failures++; $display("FAIL reset_fault: got %b want 00", stack_fault); end
        checks++; if (dut.pc_q !== 16'h0000) begin failures++; $display("FAIL reset_pc: got %h want 0000", dut.pc_q); end
        checks++; if (dut.dsp_q !== 2'd0 || dut.rsp_q !== 2'd0) begin failures++; $display("FAIL reset_sp: got dsp=%0d rsp=%0d want 0 0", dut.dsp_q, dut.rsp_q); end
        irq = 4'h0;
    endtask

    task automatic test_alu;
        for (int i = 0; i < 11; i++) begin
            begin_load;
            put(0, 16'h8000 | va[i]);
            put(1, 16'h8000 | vb[i]);
            put(2, 16'h6003 | (16'(vop[i]) << 8));
            put(3, 16'h0003);
            go;
            tick(4);
            checks++; if (io_addr !== vex[i]) begin failures++; $display("FAIL alu[%0d] T: got %h want %h", i, io_addr, vex[i]); end
            checks++; if (dut.dsp_q !== 2'd1 || io_dout !== 16'h0000) begin failures++; $display("FAIL alu[%0d] dsp/N: got %0d/%h want 1/0000", i, dut.dsp_q, io_dout); end
        end
    endtask

    task automatic test_compare_ffff;
        logic [15:0] ops [2] = '{16'h6F03, 16'h6803};
        logic [15:0] exp [2] = '{16'hFFFF, 16'h0000};
        for (int i = 0; i < 2; i++) begin
            begin_load;
            put(0, 16'h8001); put(1, 16'h8000); put(2, 16'h6600); put(3, ops[i]); put(4, 16'h0004);
            go;
            tick(4);
            checks++; if (io_addr !== 16'hFFFF || io_dout !== 16'h0001) begin failures++; $display("FAIL cmp[%0d] setup: got T=%h N=%h want ffff 0001", i, io_addr, io_dout); end
            tick(1);
            checks++; if (io_addr !== exp[i]) begin failures++; $display("FAIL cmp[%0d] result: got %h want %h", i, io_addr, exp[i]); end
        end
    endtask

    task automatic test_io_wait;
        begin_load;
        put(0, 16'h8055); put(1, 16'h9234); put(2, 16'h6040); put(3, 16'h8007); put(4, 16'h0004);
        io_ready = 1'b0;
        go;
        tick(3);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) io_ready = 1'b1;
            #1;
            checks++; if (io_wr !== 1'b1 || io_rd !== 1'b0) begin failures++; $display("FAIL io_wait[%0d] strobe: got wr=%b rd=%b want 1 0", c, io_wr, io_rd); end
            checks++; if (io_addr !== 16'h1234 || io_dout !== 16'h0055) begin failures++; $display("FAIL io_wait[%0d] bus: got %h/%h want 1234/0055", c, io_addr, io_dout); end
            checks++; if (dut.pc_q !== 16'h0004) begin failures++; $display("FAIL io_wait[%0d] pc: got %h want 0004", c, dut.pc_q); end
            tick(1);
        end
        checks++; if (io_wr !== 1'b0 || dut.pc_q !== 16'h0006) begin failures++; $display("FAIL io_wait_done: got wr=%b pc=%h want 0 0006", io_wr, dut.pc_q); end
    endtask

    task automatic test_irq;
        begin_load;
        put(0, 16'h0008); put(2, 16'h0018); put(8, 16'h6070); put(9, 16'h8011);
        put(10, 16'h8022); put(11, 16'h000B); put(24, 16'h608C);
        irq = 4'b0110;
        go;
        tick(1);
        checks++; if (irq_ack !== 4'h0) begin failures++; $display("FAIL irq_ie0_a: got %b want 0000", irq_ack); end
        tick(1);
        checks++; if (irq_ack !== 4'h0) begin failures++; $display("FAIL irq_ie0_b: got %b want 0000", irq_ack); end
        tick(1);
        checks++; if (irq_ack !== 4'b0010 || dut.pc_q !== 16'h0013) begin failures++; $display("FAIL irq_ack: got ack=%b pc=%h want 0010 0013", irq_ack, dut.pc_q); end
        tick(1);
        checks++; if (dut.pc_q !== 16'h0004 || dut.r_top !== 16'h8012 || dut.rsp_q !== 2'd1) begin failures++; $display("FAIL irq_entry: got pc=%h R=%h rsp=%0d want 0004 8012 1", dut.pc_q, dut.r_top, dut.rsp_q); end
        checks++; if (irq_ack !== 4'h0) begin failures++; $display("FAIL irq_in_isr: got %b want 0000", irq_ack); end
        irq = 4'h0;
        tick(2);
        checks++; if (dut.pc_q !== 16'h0013 || dut.rsp_q !== 2'd0) begin failures++; $display("FAIL irq_reti: got pc=%h rsp=%0d want 0013 0", dut.pc_q, dut.rsp_q); end
        tick(1);
        checks++; if (io_addr !== 16'h0011) begin failures++; $display("FAIL irq_resume: got T=%h want 0011", io_addr); end
    endtask

    task automatic test_irq_during_stall;
        begin_load;
        put(0, 16'h0008); put(1, 16'h0018); put(8, 16'h6070); put(9, 16'h8033);
        put(10, 16'h6040); put(11, 16'h8044); put(12, 16'h000C); put(24, 16'h608C);
        io_ready = 1'b0;
        go;
        tick(4);
        irq = 4'b0001;
        #1;
        checks++; if (irq_ack !== 4'h0 || io_wr !== 1'b1) begin failures++; $display("FAIL stall_irq_a: got ack=%b wr=%b want 0000 1", irq_ack, io_wr); end
        tick(1);
        checks++; if (irq_ack !== 4'h0 || dut.pc_q !== 16'h0015) begin failures++; $display("FAIL stall_irq_b: got ack=%b pc=%h want 0000 0015", irq_ack, dut.pc_q); end
        io_ready = 1'b1;
        #1;
        checks++; if (irq_ack !== 4'h0 || io_wr !== 1'b1) begin failures++; $display("FAIL stall_irq_c: got ack=%b wr=%b want 0000 1", irq_ack, io_wr); end
        tick(1);
        checks++; if (irq_ack !== 4'b0001 || io_wr !== 1'b0 || dut.pc_q !== 16'h0017) begin failures++; $display("FAIL stall_irq_d: got ack=%b wr=%b pc=%h want 0001 0 0017", irq_ack, io_wr, dut.pc_q); end
        tick(1);
        checks++; if (dut.pc_q !== 16'h0002) begin failures++; $display("FAIL stall_irq_vec: got pc=%h want 0002", dut.pc_q); end
        irq = 4'h0;
    endtask

    task automatic test_stack_fault;
        begin_load;
        put(0, 16'h8001); put(1, 16'h8002); put(2, 16'h8003); put(3, 16'h8004); put(4, 16'h0004);
        go;
        tick(4);
        checks++; if (stack_fault !== 2'b00 || dut.dsp_q !== 2'd3) begin failures++; $display("FAIL push3: got fault=%b dsp=%0d want 00 3", stack_fault, dut.dsp_q); end
        tick(1);
        checks++; if (stack_fault !== 2'b01 || dut.dsp_q !== 2'd0) begin failures++; $display("FAIL push4: got fault=%b dsp=%0d want 01 0", stack_fault, dut.dsp_q); end
        begin_load;
        put(0, 16'h6103); put(1, 16'h600C); put(2, 16'h0002);
        go;
        tick(2);
        checks++; if (stack_fault !== 2'b01 || dut.dsp_q !== 2'd3) begin failures++; $display("FAIL dpop0: got fault=%b dsp=%0d want 01 3", stack_fault, dut.dsp_q); end
        tick(1);
        checks++; if (stack_fault !== 2'b11 || dut.rsp_q !== 2'd3) begin failures++; $display("FAIL rpop0: got fault=%b rsp=%0d want 11 3", stack_fault, dut.rsp_q); end
        tick(2);
        checks++; if (stack_fault !== 2'b11) begin failures++; $display("FAIL fault_sticky: got %b want 11", stack_fault); end
    endtask

    task automatic test_reset_midcall;
        begin_load;
        put(0, 16'h600C); put(1, 16'h8009); put(2, 16'h4004); put(4, 16'h6050);
        io_ready = 1'b0;
        go;
        tick(4);
        checks++; if (io_rd !== 1'b1 || stack_fault !== 2'b10) begin failures++; $display("FAIL midcall_pre: got rd=%b fault=%b want 1 10", io_rd, stack_fault); end
        resetq = 1'b0;
        #1;
        checks++; if (io_rd !== 1'b0 || io_wr !== 1'b0) begin failures++; $display("FAIL midcall_strobes: got rd=%b wr=%b want 0 0", io_rd, io_wr); end
        checks++; if (dut.pc_q !== 16'h0000 || stack_fault !== 2'b00 || io_addr !== 16'h0000) begin failures++; $display("FAIL midcall_state: got pc=%h fault=%b T=%h want 0000 00 0000", dut.pc_q, stack_fault, io_addr); end
        tick(1);
        resetq = 1'b1;
        tick(1);
        checks++; if (dut.pc_q !== 16'h0000 || stack_fault !== 2'b00) begin failures++; $display("FAIL midcall_reboot: got pc=%h fault=%b want 0000 00", dut.pc_q, stack_fault); end
        tick(1);
        checks++; if (stack_fault !== 2'b10 || io_rd !== 1'b0 || dut.pc_q !== 16'h0002) begin failures++; $display("FAIL midcall_first: got fault=%b rd=%b pc=%h want 10 0 0002", stack_fault, io_rd, dut.pc_q); end
        io_ready = 1'b1;
    endtask

    task automatic test_data_fetch;
        begin_load;
        put(0, 16'h4004); put(1, 16'h0001); put(4, 16'hC050); put(5, 16'h6127); put(6, 16'h608C); put(40, 16'hBEEF);
        go;
        tick(6);
        checks++; if (io_addr !== 16'hBEEF) begin failures++; $display("FAIL fetch_T: got %h want beef", io_addr); end
        checks++; if (dut.pc_q !== 16'h0002 || dut.rsp_q !== 2'd0 || dut.dsp_q !== 2'd1) begin failures++; $display("FAIL fetch_ret: got pc=%h rsp=%0d dsp=%0d want 0002 0 1", dut.pc_q, dut.rsp_q, dut.dsp_q); end
        checks++; if (stack_fault !== 2'b00) begin failures++; $display("FAIL fetch_fault: got %b want 00", stack_fault); end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_compare_ffff;
        test_io_wait;
        test_irq;
        test_irq_during_stall;
        test_stack_fault;
        test_reset_midcall;
        test_data_fetch;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
